// File: rtl/fetch_ctrl_pkg.sv
// Shared CPU-side constants and types for the instruction fetch front end.
package fetch_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [3:0]  HALT_OP_DEFAULT  = 4'b1111;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StDrain  = 2'd1,
    StHalted = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// In-order instruction queue; full-with-pop may push, flush empties it in one edge.
module fetch_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam logic [AddrW:0] FullCnt = (AddrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign count_o = wptr_q - rptr_q;
  assign full_o  = (count_o == FullCnt);
  assign empty_o = (wptr_q == rptr_q);
  assign rdata_o = mem_q[rptr_q[AddrW-1:0]];

  assign do_push = push_i & (~full_o | pop_i) & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AddrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: pc register, RUN/DRAIN/HALTED FSM and queue enqueue/flush control.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned QDEPTH   = 2,
  parameter logic [3:0]  HALT_OP  = HALT_OP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        valid_o,
  input  logic        ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        halted_o
);

  localparam int unsigned CntW = $clog2(QDEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          q_push, q_pop, q_flush, q_full, q_empty;
  logic [63:0]   q_rdata;
  logic [CntW-1:0] q_count;
  logic          fire, halt_word;

  fetch_fifo #(
    .Width (64),
    .Depth (QDEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (q_flush),
    .push_i  (q_push),
    .wdata_i ({imem_data_i, pc_q}),
    .pop_i   (q_pop),
    .rdata_o (q_rdata),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  assign imem_addr_o = pc_q;
  assign valid_o     = ~q_empty;
  assign fire        = valid_o & ready_i;
  assign q_pop       = fire;
  assign instr_o     = valid_o ? q_rdata[63:32] : 32'h0;
  assign instr_pc_o  = valid_o ? q_rdata[31:0]  : 32'h0;
  assign halted_o    = (state_q == StHalted);
  assign halt_word   = (imem_data_i[31:28] == HALT_OP);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    q_push  = 1'b0;
    q_flush = 1'b0;
    unique case (state_q)
      StRun: begin
        if (redirect_i) begin
          q_flush = 1'b1;
          pc_d    = redirect_pc_i;
        end else if (~q_full || fire) begin
          if (halt_word) begin
            state_d = StDrain;
          end else begin
            q_push = 1'b1;
            pc_d   = pc_q + 32'd1;
          end
        end
      end
      StDrain: begin
        if (redirect_i) begin
          q_flush = 1'b1;
          pc_d    = redirect_pc_i;
          state_d = StRun;
        end else if (q_empty || (fire && q_count == CntW'(1))) begin
          state_d = StHalted;
        end
      end
      StHalted: ;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

endmodule
